// File: rtl/pe_ws_pipelined.sv
// Weight-stationary systolic PE: double-buffered weight chain, 1- or 2-stage MAC with a valid
// tag, signed/unsigned mode, sticky overflow flag and a psum bypass for fencing off the cell.
module pe_ws_pipelined #(
  parameter int unsigned SYSTOLIC_SIZE     = 8,
  parameter int unsigned WEIGHT_WIDTH      = 8,
  parameter int unsigned ACTIVATION_WIDTH  = 8,
  parameter int unsigned PARTIAL_SUM_WIDTH = WEIGHT_WIDTH + ACTIVATION_WIDTH
                                             + $clog2(SYSTOLIC_SIZE),
  parameter int unsigned MAC_STAGES        = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WEIGHT_WIDTH-1:0]      weight_in,
  input  logic                         weight_shift,
  input  logic                         weight_commit,
  output logic [WEIGHT_WIDTH-1:0]      weight_out,
  input  logic [ACTIVATION_WIDTH-1:0]  act_in,
  input  logic                         act_valid_in,
  output logic [ACTIVATION_WIDTH-1:0]  act_out,
  output logic                         act_valid_out,
  input  logic [PARTIAL_SUM_WIDTH-1:0] psum_in,
  output logic [PARTIAL_SUM_WIDTH-1:0] psum_out,
  output logic                         psum_valid_out,
  input  logic                         signed_mode,
  input  logic                         bypass,
  input  logic                         ovf_clear,
  output logic                         ovf_flag
);

  localparam int unsigned W   = WEIGHT_WIDTH;
  localparam int unsigned A   = ACTIVATION_WIDTH;
  localparam int unsigned PSW = PARTIAL_SUM_WIDTH;

  logic [W-1:0]   shadow_q, shadow_d, active_q, active_d;
  logic [A-1:0]   act_q, act_d;
  logic           act_valid_q, act_valid_d;
  logic [PSW-1:0] s1_prod_q, s1_prod_d, s1_psum_q, s1_psum_d;
  logic           s1_signed_q, s1_signed_d, s1_bypass_q, s1_bypass_d;
  logic           s1_valid_q, s1_valid_d;
  logic [PSW-1:0] psum_q, psum_d;
  logic           psum_valid_q, psum_valid_d;
  logic           ovf_q, ovf_d;

  logic [PSW-1:0] act_ext, wgt_ext, prod;
  logic [PSW-1:0] f_prod, f_psum, sum;
  logic [PSW:0]   sum_ext;
  logic           f_signed, f_bypass, f_valid, ovf_now;

  // Operands are widened to PSW first so the truncated product is exact in both modes.
  always_comb begin
    act_ext = {{(PSW-A){signed_mode & act_in[A-1]}}, act_in};
    wgt_ext = {{(PSW-W){signed_mode & active_q[W-1]}}, active_q};
    prod    = act_ext * wgt_ext;
  end

  // Final-stage operands: straight from the inputs, or from the stage-1 registers.
  always_comb begin
    if (MAC_STAGES == 2) begin
      f_prod   = s1_prod_q;
      f_psum   = s1_psum_q;
      f_signed = s1_signed_q;
      f_bypass = s1_bypass_q;
      f_valid  = s1_valid_q;
    end else begin
      f_prod   = prod;
      f_psum   = psum_in;
      f_signed = signed_mode;
      f_bypass = bypass;
      f_valid  = act_valid_in;
    end
  end

  always_comb begin
    sum_ext = {1'b0, f_psum} + {1'b0, f_prod};
    sum     = sum_ext[PSW-1:0];
    if (f_signed) begin
      ovf_now = (f_psum[PSW-1] == f_prod[PSW-1]) && (sum[PSW-1] != f_psum[PSW-1]);
    end else begin
      ovf_now = sum_ext[PSW];
    end
  end

  always_comb begin
    shadow_d     = shadow_q;
    active_d     = active_q;
    s1_prod_d    = s1_prod_q;
    s1_psum_d    = s1_psum_q;
    s1_signed_d  = s1_signed_q;
    s1_bypass_d  = s1_bypass_q;
    s1_valid_d   = act_valid_in;
    psum_d       = psum_q;
    psum_valid_d = f_valid;
    ovf_d        = ovf_q;
    act_d        = act_in;
    act_valid_d  = act_valid_in;

    // Commit reads the pre-shift shadow, so shift+commit together loads the old value.
    if (weight_commit) active_d = shadow_q;
    if (weight_shift)  shadow_d = weight_in;

    if (act_valid_in) begin
      s1_prod_d   = prod;
      s1_psum_d   = psum_in;
      s1_signed_d = signed_mode;
      s1_bypass_d = bypass;
    end

    if (f_valid) psum_d = f_bypass ? f_psum : sum;

    if (ovf_clear) ovf_d = 1'b0;
    if (f_valid && !f_bypass && ovf_now) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q     <= '0;
      active_q     <= '0;
      act_q        <= '0;
      act_valid_q  <= 1'b0;
      s1_prod_q    <= '0;
      s1_psum_q    <= '0;
      s1_signed_q  <= 1'b0;
      s1_bypass_q  <= 1'b0;
      s1_valid_q   <= 1'b0;
      psum_q       <= '0;
      psum_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      act_q        <= act_d;
      act_valid_q  <= act_valid_d;
      s1_prod_q    <= s1_prod_d;
      s1_psum_q    <= s1_psum_d;
      s1_signed_q  <= s1_signed_d;
      s1_bypass_q  <= s1_bypass_d;
      s1_valid_q   <= s1_valid_d;
      psum_q       <= psum_d;
      psum_valid_q <= psum_valid_d;
      ovf_q        <= ovf_d;
    end
  end

  assign weight_out     = shadow_q;
  assign act_out        = act_q;
  assign act_valid_out  = act_valid_q;
  assign psum_out       = psum_q;
  assign psum_valid_out = psum_valid_q;
  assign ovf_flag       = ovf_q;

endmodule
